// File: rtl/serial_rbs_sub.sv
// Bit-serial ripple-borrow subtractor: diff = (a - b - bin) mod 2^N, borrow-out, zero flag.
// Latency: operands accepted at edge k, result valid after edge k+N (N RUN cycles).
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE (one op per N+2 cycles min).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     operand handshake carrying a, b (N bits) and bin
//   out_valid/out_ready   result handshake carrying diff (N bits), bout, zero
module serial_rbs_sub #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] diff,
  output logic         bout,
  output logic         zero
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [N-1:0]  res_q, res_d;
  logic [N-1:0]  diff_q, diff_d;
  logic          br_q, br_d;
  logic          bout_q, bout_d;
  logic          zero_q, zero_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          d_bit;
  logic          br_next;
  logic [N-1:0]  res_sh;

  // One full-subtractor slice on the current LSBs; the new difference bit
  // enters the result from the MSB end so after N shifts it is aligned.
  always_comb begin
    d_bit       = a_q[0] ^ b_q[0] ^ br_q;
    br_next     = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    res_sh      = res_q >> 1;
    res_sh[N-1] = d_bit;
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    br_d      = br_q;
    cnt_d     = cnt_q;
    diff_d    = diff_q;
    bout_d    = bout_q;
    zero_d    = zero_q;
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          res_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = br_next;
        res_d = res_sh;
        cnt_d = cnt_q + CW'(1);
        // Last bit: publish the shifted-in result directly so DONE sees it
        // on the same edge.
        if (cnt_q == LAST) begin
          diff_d  = res_sh;
          bout_d  = br_next;
          zero_d  = (res_sh == '0);
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      zero_q  <= zero_d;
    end
  end

  assign diff = diff_q;
  assign bout = bout_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_serial_rbs_sub.sv
module tb_serial_rbs_sub;

  typedef struct {
    logic [7:0] diff;
    logic       bout;
    logic       zero;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int assertions = 0;
  int failures = 0;

  // N=4 instance
  logic       in_valid4 = 1'b0, in_ready4, out_valid4, out_ready4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0, diff4;
  logic       bin4 = 1'b0, bout4, zero4;
  exp_t       q4[$];

  // N=1 instance
  logic       in_valid1 = 1'b0, in_ready1, out_valid1, out_ready1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0, diff1;
  logic       bin1 = 1'b0, bout1, zero1;
  exp_t       q1[$];

  // N=8 instance
  logic       in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, diff8;
  logic       bin8 = 1'b0, bout8, zero8;
  exp_t       q8[$];

  serial_rbs_sub #(.N(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .bin(bin4), .out_valid(out_valid4), .out_ready(out_ready4),
    .diff(diff4), .bout(bout4), .zero(zero4));

  serial_rbs_sub #(.N(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .bin(bin1), .out_valid(out_valid1), .out_ready(out_ready1),
    .diff(diff1), .bout(bout1), .zero(zero1));

  serial_rbs_sub #(.N(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .bin(bin8), .out_valid(out_valid8), .out_ready(out_ready8),
    .diff(diff8), .bout(bout8), .zero(zero8));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    assertions++; if (in_ready4 !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready4); end
    assertions++; if (out_valid4 !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid4); end
    assertions++; if (diff4 !== 4'd0) begin failures++; $display("FAIL reset_diff: got %0d expected 0", diff4); end
    assertions++; if ({bout4, zero4} !== 2'b00) begin failures++; $display("FAIL reset_bout_zero: got %b expected 00", {bout4, zero4}); end
    assertions++; if ({out_valid1, out_valid8} !== 2'b00) begin failures++; $display("FAIL reset_out_valid_n1n8: got %b expected 00", {out_valid1, out_valid8}); end
    rst_n = 1'b1;
    tick();
    assertions++; if ({in_ready4, out_valid4} !== 2'b10) begin failures++; $display("FAIL post_reset_idle: got %b expected 10", {in_ready4, out_valid4}); end
  endtask

  // One N=4 operation with out_ready held high; checks latency, result and return to IDLE.
  task automatic run_op4(input logic [3:0] av, input logic [3:0] bv, input logic binv,
                         input logic [3:0] ed, input logic eb, input logic ez, input string name);
    int   lat;
    exp_t e;
    exp_t got;
    assertions++; if (in_ready4 !== 1'b1) begin failures++; $display("FAIL %s_ready_before: got %b expected 1", name, in_ready4); end
    a4 = av; b4 = bv; bin4 = binv; in_valid4 = 1'b1; out_ready4 = 1'b1;
    e.diff = {4'd0, ed}; e.bout = eb; e.zero = ez;
    q4.push_back(e);
    tick();
    in_valid4 = 1'b0;
    lat = 0;
    while (!out_valid4 && lat < 20) begin
      tick();
      lat++;
    end
    assertions++; if (lat != 4) begin failures++; $display("FAIL %s_latency: got %0d expected 4", name, lat); end
    if (out_valid4 && q4.size() > 0) begin
      got = q4.pop_front();
      assertions++; if (diff4 !== got.diff[3:0]) begin failures++; $display("FAIL %s_diff: got %0d expected %0d", name, diff4, got.diff[3:0]); end
      assertions++; if (bout4 !== got.bout) begin failures++; $display("FAIL %s_bout: got %b expected %b", name, bout4, got.bout); end
      assertions++; if (zero4 !== got.zero) begin failures++; $display("FAIL %s_zero: got %b expected %b", name, zero4, got.zero); end
    end
    tick();
    assertions++; if ({in_ready4, out_valid4} !== 2'b10) begin failures++; $display("FAIL %s_back_to_idle: got %b expected 10", name, {in_ready4, out_valid4}); end
  endtask

  task automatic test_basic();
    run_op4(4'd9, 4'd5, 1'b0, 4'd4, 1'b0, 1'b0, "basic_9_5");
  endtask

  task automatic test_borrow_zero();
    run_op4(4'd3, 4'd5, 1'b0, 4'd14, 1'b1, 1'b0, "borrow_3_5");
    run_op4(4'd0, 4'd15, 1'b1, 4'd0, 1'b1, 1'b1, "wrap_0_15_1");
    run_op4(4'd7, 4'd7, 1'b0, 4'd0, 1'b0, 1'b1, "zero_7_7");
  endtask

  task automatic test_backpressure();
    int wait_c;
    a4 = 4'd12; b4 = 4'd4; bin4 = 1'b1; in_valid4 = 1'b1; out_ready4 = 1'b0;
    tick();
    in_valid4 = 1'b0;
    wait_c = 0;
    while (!out_valid4 && wait_c < 20) begin tick(); wait_c++; end
    assertions++; if (out_valid4 !== 1'b1) begin failures++; $display("FAIL bp_done_timeout: got %b expected 1", out_valid4); end
    // New operands offered while the result is stalled must be ignored.
    a4 = 4'd15; b4 = 4'd0; bin4 = 1'b0; in_valid4 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      assertions++; if ({out_valid4, in_ready4} !== 2'b10) begin failures++; $display("FAIL bp_hold_hs[%0d]: got %b expected 10", i, {out_valid4, in_ready4}); end
      assertions++; if ({diff4, bout4, zero4} !== {4'd7, 1'b0, 1'b0}) begin failures++; $display("FAIL bp_hold_result[%0d]: got diff=%0d bout=%b zero=%b expected diff=7 bout=0 zero=0", i, diff4, bout4, zero4); end
      tick();
    end
    out_ready4 = 1'b1;
    tick();
    assertions++; if ({in_ready4, out_valid4} !== 2'b10) begin failures++; $display("FAIL bp_release_idle: got %b expected 10", {in_ready4, out_valid4}); end
    tick();
    in_valid4 = 1'b0;
    assertions++; if (in_ready4 !== 1'b0) begin failures++; $display("FAIL bp_new_accept: got in_ready %b expected 0", in_ready4); end
    wait_c = 0;
    while (!out_valid4 && wait_c < 20) begin tick(); wait_c++; end
    assertions++; if ({out_valid4, diff4, bout4} !== {1'b1, 4'd15, 1'b0}) begin failures++; $display("FAIL bp_new_result: got valid=%b diff=%0d bout=%b expected valid=1 diff=15 bout=0", out_valid4, diff4, bout4); end
    tick();
  endtask

  task automatic test_reset_mid_run();
    int seen;
    a4 = 4'd10; b4 = 4'd3; bin4 = 1'b0; in_valid4 = 1'b1; out_ready4 = 1'b1;
    tick();
    in_valid4 = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    assertions++; if ({in_ready4, out_valid4} !== 2'b10) begin failures++; $display("FAIL midrun_reset_hs: got %b expected 10", {in_ready4, out_valid4}); end
    assertions++; if ({diff4, bout4, zero4} !== 6'd0) begin failures++; $display("FAIL midrun_reset_result: got diff=%0d bout=%b zero=%b expected 0 0 0", diff4, bout4, zero4); end
    q4.delete();
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid4) seen++;
    end
    assertions++; if (seen != 0) begin failures++; $display("FAIL midrun_no_stale_result: got %0d valid cycles expected 0", seen); end
    run_op4(4'd1, 4'd2, 1'b0, 4'd15, 1'b1, 1'b0, "after_reset_1_2");
  endtask

  task automatic test_n1();
    logic [2:0] iv;
    logic [1:0] t;
    int   lat;
    exp_t e;
    exp_t got;
    out_ready1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      iv = i[2:0];
      t = {1'b0, iv[2]} - {1'b0, iv[1]} - {1'b0, iv[0]};
      e.diff = {7'd0, t[0]}; e.bout = t[1]; e.zero = ~t[0];
      a1 = iv[2]; b1 = iv[1]; bin1 = iv[0]; in_valid1 = 1'b1;
      assertions++; if (in_ready1 !== 1'b1) begin failures++; $display("FAIL n1_ready[%0d]: got %b expected 1", i, in_ready1); end
      q1.push_back(e);
      tick();
      in_valid1 = 1'b0;
      lat = 0;
      while (!out_valid1 && lat < 10) begin tick(); lat++; end
      assertions++; if (lat != 1) begin failures++; $display("FAIL n1_latency[%0d]: got %0d expected 1", i, lat); end
      if (out_valid1 && q1.size() > 0) begin
        got = q1.pop_front();
        assertions++; if ({diff1, bout1, zero1} !== {got.diff[0], got.bout, got.zero}) begin failures++; $display("FAIL n1_result[%0d]: got %b%b%b expected %b%b%b", i, diff1, bout1, zero1, got.diff[0], got.bout, got.zero); end
      end
      tick();
    end
  endtask

  task automatic test_random8();
    localparam int NUM = 1000;
    int rcv = 0;
    int cyc = 0;
    int timeouts = 0;
    fork
      begin : driver
        logic [8:0] t;
        exp_t e;
        int   w;
        for (int k = 0; k < NUM; k++) begin
          in_valid8 = 1'b0;
          repeat ($urandom_range(0, 2)) tick();
          a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
          in_valid8 = 1'b1;
          w = 0;
          while (!in_ready8 && w < 40) begin tick(); w++; end
          if (!in_ready8) begin
            timeouts++;
          end else begin
            t = {1'b0, a8} - {1'b0, b8} - {8'd0, bin8};
            e.diff = t[7:0]; e.bout = t[8]; e.zero = (t[7:0] == 8'd0);
            q8.push_back(e);
            tick();
          end
        end
        in_valid8 = 1'b0;
      end
      begin : monitor
        exp_t got;
        while (rcv < NUM && cyc < 40000) begin
          tick();
          cyc++;
          out_ready8 = ($urandom_range(0, 3) != 0);
          // Handshake will complete on the next edge; compare now while stable.
          if (out_valid8 && out_ready8) begin
            assertions++;
            if (q8.size() == 0) begin
              failures++; $display("FAIL rnd_unexpected_result: got diff=%0d expected none", diff8);
            end else begin
              got = q8.pop_front();
              if ({diff8, bout8, zero8} !== {got.diff, got.bout, got.zero}) begin
                failures++; $display("FAIL rnd_result[%0d]: got diff=%0d bout=%b zero=%b expected diff=%0d bout=%b zero=%b", rcv, diff8, bout8, zero8, got.diff, got.bout, got.zero);
              end
            end
            rcv++;
          end
        end
        out_ready8 = 1'b0;
      end
    join
    assertions++; if (rcv != NUM) begin failures++; $display("FAIL rnd_count: got %0d expected %0d", rcv, NUM); end
    assertions++; if (q8.size() != 0) begin failures++; $display("FAIL rnd_leftover: got %0d expected 0", q8.size()); end
    assertions++; if (timeouts != 0) begin failures++; $display("FAIL rnd_accept_timeout: got %0d expected 0", timeouts); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow_zero();
    test_backpressure();
    test_reset_mid_run();
    test_n1();
    test_random8();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/serial_rbs_sub.md
Name: serial_rbs_sub

Overview:
Bit-serial ripple-borrow subtractor, the subtract counterpart of the combinational ripple-carry adder.
- Accepts two N-bit operands and a borrow-in over a valid/ready handshake.
- Computes a - b - bin LSB-first, one full-subtractor bit per clock, then holds the result on a second valid/ready handshake.
- Used where a full-width combinational subtract path is too costly in area; trades area for N cycles of latency.

Parameters:
- N, 4, operand/result width in bits; legal range N >= 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand bundle valid.
- in_ready  output  1  block can accept operands.
- a  input  N  minuend.
- b  input  N  subtrahend.
- bin  input  1  borrow-in.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- diff  output  N  (a - b - bin) mod 2^N.
- bout  output  1  borrow-out; 1 iff a < b + bin (unsigned).
- zero  output  1  diff == 0.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset: state = IDLE, internal counters/shift registers = 0.
  - Outputs during and after reset: in_ready = 1 (IDLE), out_valid = 0, diff = 0, bout = 0, zero = 0.
- States:
  - IDLE: in_ready = 1, out_valid = 0.
  - RUN: in_ready = 0, out_valid = 0.
  - DONE: in_ready = 0, out_valid = 1.
- Input handshake:
  - Transfer on a rising edge with in_valid & in_ready.
  - At that edge, capture a, b, bin into internal registers, clear bit counter, go to RUN.
  - a, b, bin are ignored whenever in_ready = 0.
- RUN datapath, per cycle on LSB bits a0, b0 and running borrow br:
  - d = a0 ^ b0 ^ br.
  - br_next = (~a0 & b0) | (~(a0 ^ b0) & br).
  - d shifts into the result register from the MSB end.
  - Operand registers shift right by one.
  - Counter increments.
- RUN exit: on the edge completing bit N-1:
  - diff <= full result.
  - bout <= final borrow.
  - zero <= (result == 0).
  - state <= DONE.
- Latency:
  - Accept at edge k; out_valid rises after edge k+N.
  - Exactly N RUN cycles, including N = 1.
- Counter width: clog2(N+1) bits. No wrap-around inside RUN; the counter clears on accept.
- DONE:
  - diff, bout, zero are held stable until out_valid & out_ready at a rising edge.
  - At that edge, go to IDLE; in_ready = 1 from the next cycle.
  - No same-cycle re-accept: throughput is one operation per N+2 cycles minimum.
- out_ready has no effect outside DONE.
- Result registers keep their last values in IDLE/RUN; they are only meaningful while out_valid = 1.
- Reset mid-operation (rst_n low in RUN or DONE):
  - Abort immediately; return to IDLE with all reset values.
  - The pending result is discarded, with no out_valid pulse.
- All outputs are registered or decoded from the state register only. No combinational path from inputs to outputs.

Test Plan:
- N=4; a=9, b=5, bin=0, out_ready=1 -> out_valid exactly 4 cycles after accept edge; diff=4, bout=0, zero=0; in_ready=1 one cycle after result handshake.
- N=4; a=3, b=5, bin=0 -> diff=14, bout=1, zero=0. Then a=0, b=15, bin=1 -> diff=0, bout=1, zero=1. Then a=7, b=7, bin=0 -> diff=0, bout=0, zero=1.
- Backpressure: a=12, b=4, bin=1; hold out_ready=0 for 5 cycles in DONE, with in_valid=1 and new operands driven -> diff=7, bout=0 stable throughout; in_ready=0; new operands not captured; release out_ready -> IDLE, then new operands accepted.
- Reset mid-RUN: accept a=10, b=3; assert rst_n=0 after 2 RUN cycles -> in_ready=1, out_valid=0, diff=0 immediately; after release, a=1, b=2, bin=0 -> diff=15, bout=1.
- Parameter sweep: N=1 (all 8 input combos, latency 1) and N=8 (1000 random operands with random in_valid/out_ready stalls) -> diff/bout/zero match reference model (a - b - bin) mod 2^N, borrow = a < b+bin; every result delivered exactly once, in order.
